// File: rtl/freq_meter_pkg.sv
// Shared definitions for the BCD frequency meter: FSM encoding, gate
// selection codes and the timing helpers that turn CLK_HZ into gate lengths.
package freq_meter_pkg;

  // Measurement sequencer states. The encoding is stable so that a checker
  // bound to freq_meter_bcd.state_q can decode it directly.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_GATE  = 2'd2,
    ST_LATCH = 2'd3
  } state_e;

  // gate_sel codes: window length is one base tick times a power of ten.
  localparam logic [1:0] GSEL_10MS  = 2'b00;
  localparam logic [1:0] GSEL_100MS = 2'b01;
  localparam logic [1:0] GSEL_1S    = 2'b10;
  localparam logic [1:0] GSEL_10S   = 2'b11;

  // Width of the gate-decade counter; must hold DECADE_TICKS[3]-1 = 999.
  localparam int unsigned DEC_W = 10;

  // Number of base ticks in a window, indexed by gate_sel.
  localparam logic [DEC_W-1:0] DECADE_TICKS [4] = '{
    10'd1, 10'd10, 10'd100, 10'd1000
  };

  // Base tick period in sysclk cycles (10 ms).
  function automatic int unsigned tick_div(input int unsigned clk_hz);
    return clk_hz / 100;
  endfunction

  // Prescaler width for a given tick period; at least one bit.
  function automatic int unsigned pre_width(input int unsigned ticks);
    return (ticks > 1) ? $clog2(ticks) : 1;
  endfunction

endpackage

// File: rtl/freq_meter_bcd_digit.sv
// One BCD decade of the edge counter. Counts 0..9 on inc, wraps 9->0 and
// raises carry in the same cycle so the next decade can follow.
module bcd_digit (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] q,
  output logic       carry
);

  logic [3:0] q_q;
  logic [3:0] q_d;

  // Next digit value: clear wins, otherwise step with decimal wrap.
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = 4'd0;
    end else if (inc) begin
      q_d = (q_q == 4'd9) ? 4'd0 : q_q + 4'd1;
    end
  end

  // Digit register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= 4'd0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q     = q_q;
  assign carry = inc & (q_q == 4'd9);

endmodule

// File: rtl/freq_meter_bcd.sv
// BCD frequency meter: counts synchronised rising edges of clkin during a
// gate window of 10 ms..10 s and latches the count with range and overflow.
//
// Result interface: result_valid is a one-cycle strobe with no ready; the
// result_* outputs change only in the strobe cycle and hold until the next
// strobe, so a consumer may sample them at any time or on the strobe.
module freq_meter_bcd
  import freq_meter_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned DIGITS = 8
) (
  input  logic                  sysclk,
  input  logic                  rst,
  input  logic                  clkin,
  input  logic [1:0]            gate_sel,
  input  logic                  start,
  input  logic                  cont,
  output logic [4*DIGITS-1:0]   result_bcd,
  output logic [1:0]            result_range,
  output logic                  result_ovf,
  output logic                  result_valid,
  output logic                  busy
);

  localparam int unsigned      TICKS    = tick_div(CLK_HZ);
  localparam int unsigned      PRE_W    = pre_width(TICKS);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS - 1);

  // ---------------------------------------------------------------------
  // Input path: two-flop synchroniser plus a history flop for edge detect.
  // ---------------------------------------------------------------------
  logic sync1_q;
  logic sync2_q;
  logic hist_q;
  logic edge_w;

  // Bring clkin into the sysclk domain and keep one cycle of history.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      sync1_q <= clkin;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign edge_w = sync2_q & ~hist_q;

  // ---------------------------------------------------------------------
  // Sequencer FSM. state_q is the observable state for debug and checkers.
  // ---------------------------------------------------------------------
  state_e state_q;
  state_e state_d;
  logic   in_arm;
  logic   in_gate;
  logic   in_latch;
  logic   gate_last;

  // State register.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start | cont) state_d = ST_ARM;
      ST_ARM:   state_d = ST_GATE;
      ST_GATE:  if (gate_last) state_d = ST_LATCH;
      ST_LATCH: state_d = cont ? ST_ARM : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State decodes used by the datapath and the busy output.
  always_comb begin
    in_arm   = (state_q == ST_ARM);
    in_gate  = (state_q == ST_GATE);
    in_latch = (state_q == ST_LATCH);
    busy     = (state_q != ST_IDLE);
  end

  // ---------------------------------------------------------------------
  // Gate timing: prescaler produces 10 ms ticks, decade counter counts
  // ticks up to the window length captured in ARM.
  // ---------------------------------------------------------------------
  logic [1:0]       gsel_q;
  logic [1:0]       gsel_d;
  logic [PRE_W-1:0] pre_q;
  logic [PRE_W-1:0] pre_d;
  logic [DEC_W-1:0] dec_q;
  logic [DEC_W-1:0] dec_d;
  logic [DEC_W-1:0] dec_last;

  assign dec_last  = DECADE_TICKS[gsel_q] - DEC_W'(1);
  assign gate_last = in_gate && (pre_q == PRE_LAST) && (dec_q == dec_last);

  // Window timers: cleared in ARM, advanced every GATE cycle.
  always_comb begin
    gsel_d = gsel_q;
    pre_d  = pre_q;
    dec_d  = dec_q;
    if (in_arm) begin
      gsel_d = gate_sel;
      pre_d  = '0;
      dec_d  = '0;
    end else if (in_gate) begin
      if (pre_q == PRE_LAST) begin
        pre_d = '0;
        dec_d = dec_q + DEC_W'(1);
      end else begin
        pre_d = pre_q + PRE_W'(1);
      end
    end
  end

  // Timer registers.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      gsel_q <= 2'b00;
      pre_q  <= '0;
      dec_q  <= '0;
    end else begin
      gsel_q <= gsel_d;
      pre_q  <= pre_d;
      dec_q  <= dec_d;
    end
  end

  // ---------------------------------------------------------------------
  // BCD edge counter with saturation at all nines.
  // ---------------------------------------------------------------------
  logic [4*DIGITS-1:0] count_w;
  logic [DIGITS-1:0]   inc_w;
  logic [DIGITS-1:0]   carry_w;
  logic                all_nine;
  logic                hit;
  logic                count_en;
  logic                top_carry_unused;
  logic                ovf_q;
  logic                ovf_d;

  // The counter is full when every digit reads nine.
  always_comb begin
    all_nine = 1'b1;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (count_w[4*k +: 4] != 4'd9) all_nine = 1'b0;
    end
  end

  assign hit      = in_gate & edge_w;
  assign count_en = hit & ~all_nine;

  genvar g;
  generate
    for (g = 0; g < int'(DIGITS); g++) begin : g_digit
      if (g == 0) begin : g_lsd
        assign inc_w[g] = count_en;
      end else begin : g_upper
        assign inc_w[g] = carry_w[g-1];
      end
      bcd_digit u_digit (
        .clk   (sysclk),
        .rst   (rst),
        .clr   (in_arm),
        .inc   (inc_w[g]),
        .q     (count_w[4*g +: 4]),
        .carry (carry_w[g])
      );
    end
  endgenerate

  // Saturation blocks the top carry, so it never leaves the counter.
  assign top_carry_unused = carry_w[DIGITS-1];

  // Overflow flag: sticky within a window, cleared when the next one arms.
  always_comb begin
    ovf_d = ovf_q;
    if (in_arm) begin
      ovf_d = 1'b0;
    end else if (hit && all_nine) begin
      ovf_d = 1'b1;
    end
  end

  // Overflow register.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  // ---------------------------------------------------------------------
  // Result registers, loaded on the edge that leaves LATCH.
  // ---------------------------------------------------------------------
  logic [4*DIGITS-1:0] res_bcd_q;
  logic [4*DIGITS-1:0] res_bcd_d;
  logic [1:0]          res_range_q;
  logic [1:0]          res_range_d;
  logic                res_ovf_q;
  logic                res_ovf_d;
  logic                res_valid_q;

  // Hold the previous result except in LATCH.
  always_comb begin
    res_bcd_d   = res_bcd_q;
    res_range_d = res_range_q;
    res_ovf_d   = res_ovf_q;
    if (in_latch) begin
      res_bcd_d   = count_w;
      res_range_d = gsel_q;
      res_ovf_d   = ovf_q;
    end
  end

  // Result and strobe registers.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      res_bcd_q   <= '0;
      res_range_q <= 2'b00;
      res_ovf_q   <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      res_bcd_q   <= res_bcd_d;
      res_range_q <= res_range_d;
      res_ovf_q   <= res_ovf_d;
      res_valid_q <= in_latch;
    end
  end

  assign result_bcd   = res_bcd_q;
  assign result_range = res_range_q;
  assign result_ovf   = res_ovf_q;
  assign result_valid = res_valid_q;

endmodule

// File: tb/tb_freq_meter_bcd.sv
// Directed bench for freq_meter_bcd with CLK_HZ=1000 (10-cycle tick).
// dut_a has 8 digits, dut_b has 2 digits for the saturation case.
module tb_freq_meter_bcd;

  localparam int unsigned CLK_HZ = 1000;

  // Clock / reset / shared stimulus
  logic        sysclk = 1'b0;
  logic        rst;
  logic        clkin = 1'b0;
  int          clk_period = 0;
  int          ph = 0;

  logic [1:0]  gate_sel_a;
  logic        start_a;
  logic        cont_a;
  logic [31:0] bcd_a;
  logic [1:0]  range_a;
  logic        ovf_a;
  logic        valid_a;
  logic        busy_a;

  logic [1:0]  gate_sel_b;
  logic        start_b;
  logic [7:0]  bcd_b;
  logic [1:0]  range_b;
  logic        ovf_b;
  logic        valid_b;
  logic        busy_b;

  int vectors     = 0;
  int miscompares = 0;

  always #5 sysclk = ~sysclk;

  // Phase-locked clkin generator: period in sysclk cycles, 0 = held low.
  always @(negedge sysclk) begin
    if (clk_period == 0) begin
      ph    = 0;
      clkin = 1'b0;
    end else begin
      ph    = (ph + 1) % clk_period;
      clkin = (ph < clk_period / 2);
    end
  end

  freq_meter_bcd #(.CLK_HZ(CLK_HZ), .DIGITS(8)) dut_a (
    .sysclk       (sysclk),
    .rst          (rst),
    .clkin        (clkin),
    .gate_sel     (gate_sel_a),
    .start        (start_a),
    .cont         (cont_a),
    .result_bcd   (bcd_a),
    .result_range (range_a),
    .result_ovf   (ovf_a),
    .result_valid (valid_a),
    .busy         (busy_a)
  );

  freq_meter_bcd #(.CLK_HZ(CLK_HZ), .DIGITS(2)) dut_b (
    .sysclk       (sysclk),
    .rst          (rst),
    .clkin        (clkin),
    .gate_sel     (gate_sel_b),
    .start        (start_b),
    .cont         (1'b0),
    .result_bcd   (bcd_b),
    .result_range (range_b),
    .result_ovf   (ovf_b),
    .result_valid (valid_b),
    .busy         (busy_b)
  );

  // Driver helpers: all driving and sampling happens 1 ns after posedge.
  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1;
    step();
    start_a = 1'b0;
  endtask

  // Steps until the selected strobe is seen; n = -1 if the budget runs out.
  task automatic wait_strobe(input bit use_b, input int max_cycles, output int n);
    bit seen;
    seen = 1'b0;
    n = -1;
    for (int i = 1; i <= max_cycles && !seen; i++) begin
      step();
      if ((use_b ? valid_b : valid_a) === 1'b1) begin
        n = i;
        seen = 1'b1;
      end
    end
  endtask

  task automatic count_strobes(input bit use_b, input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if ((use_b ? valid_b : valid_a) === 1'b1) cnt++;
    end
  endtask

  // Watchdog against a stuck run.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int c;
    rst        = 1'b1;
    gate_sel_a = 2'b00;
    start_a    = 1'b0;
    cont_a     = 1'b0;
    gate_sel_b = 2'b00;
    start_b    = 1'b0;
    repeat (3) step();

    // Reset state
    check("rst_bcd",   bcd_a,   32'h0);
    check("rst_range", range_a, 2'b00);
    check("rst_ovf",   ovf_a,   1'b0);
    check("rst_valid", valid_a, 1'b0);
    check("rst_busy",  busy_a,  1'b0);
    rst = 1'b0;
    step();

    // Single shot, 100 ms window, period-4 clkin -> 25 edges after 102 cycles
    clk_period = 4;
    repeat (8) step();
    gate_sel_a = 2'b01;
    pulse_start_a();
    check("t1_busy", busy_a, 1'b1);
    wait_strobe(1'b0, 200, n);
    check("t1_latency", n, 102);
    check("t1_bcd",   bcd_a,   32'h25);
    check("t1_range", range_a, 2'b01);
    check("t1_ovf",   ovf_a,   1'b0);
    step();
    check("t1_strobe_width", valid_a, 1'b0);
    check("t1_idle",  busy_a,  1'b0);
    check("t1_hold",  bcd_a,   32'h25);

    // Two digits, 1 s window, 250 edges -> saturate at 99 with overflow
    gate_sel_b = 2'b10;
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    wait_strobe(1'b1, 1100, n);
    check("t2_latency", n, 1002);
    check("t2_bcd",   bcd_b,   8'h99);
    check("t2_ovf",   ovf_b,   1'b1);
    check("t2_range", range_b, 2'b10);
    count_strobes(1'b1, 30, c);
    check("t2_single_strobe", c, 0);

    // Next window re-arms overflow: static clkin, 10 ms -> 00, no ovf
    clk_period = 0;
    repeat (8) step();
    gate_sel_b = 2'b00;
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    wait_strobe(1'b1, 50, n);
    check("t2b_latency", n, 12);
    check("t2b_bcd", bcd_b, 8'h00);
    check("t2b_ovf", ovf_b, 1'b0);

    // Continuous mode, 10 ms window, period-2 clkin -> 5 every 12 cycles
    clk_period = 2;
    repeat (8) step();
    gate_sel_a = 2'b00;
    cont_a = 1'b1;
    wait_strobe(1'b0, 40, n);
    check("t3_first_bcd", bcd_a, 32'h5);
    check("t3_first_range", range_a, 2'b00);
    for (int k = 0; k < 2; k++) begin
      wait_strobe(1'b0, 40, n);
      check("t3_period", n, 12);
      check("t3_bcd", bcd_a, 32'h5);
    end
    cont_a = 1'b0;
    wait_strobe(1'b0, 40, n);
    check("t3_last_period", n, 12);
    check("t3_last_bcd", bcd_a, 32'h5);
    count_strobes(1'b0, 40, c);
    check("t3_stopped", c, 0);
    check("t3_idle", busy_a, 1'b0);

    // Reset mid-GATE: outputs clear at once, no strobe, then a clean count
    clk_period = 4;
    repeat (8) step();
    gate_sel_a = 2'b01;
    pulse_start_a();
    repeat (50) step();
    check("t4_in_gate", busy_a, 1'b1);
    rst = 1'b1;
    #1;
    check("t4_rst_bcd",   bcd_a,   32'h0);
    check("t4_rst_busy",  busy_a,  1'b0);
    check("t4_rst_valid", valid_a, 1'b0);
    step();
    rst = 1'b0;
    count_strobes(1'b0, 150, c);
    check("t4_no_strobe", c, 0);
    pulse_start_a();
    wait_strobe(1'b0, 200, n);
    check("t4_latency", n, 102);
    check("t4_bcd",   bcd_a,   32'h25);
    check("t4_range", range_a, 2'b01);

    // gate_sel changed mid-window has no effect until the next ARM
    gate_sel_a = 2'b01;
    pulse_start_a();
    repeat (40) step();
    gate_sel_a = 2'b11;
    wait_strobe(1'b0, 200, n);
    check("t5_latency", n, 62);
    check("t5_bcd",   bcd_a,   32'h25);
    check("t5_range", range_a, 2'b01);
    pulse_start_a();
    wait_strobe(1'b0, 10100, n);
    check("t5_10s_latency", n, 10002);
    check("t5_10s_bcd",   bcd_a,   32'h2500);
    check("t5_10s_range", range_a, 2'b11);
    check("t5_10s_ovf",   ovf_a,   1'b0);

    // start during GATE ignored, static clkin -> 0, exactly one strobe
    clk_period = 0;
    repeat (8) step();
    gate_sel_a = 2'b00;
    pulse_start_a();
    repeat (5) step();
    check("t6_in_gate", busy_a, 1'b1);
    pulse_start_a();
    count_strobes(1'b0, 40, c);
    check("t6_strobes", c, 1);
    check("t6_bcd",   bcd_a,   32'h0);
    check("t6_range", range_a, 2'b00);
    check("t6_idle",  busy_a,  1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
